calc1_port_requester: RTL and testbench

CALC1_PORT_REQUESTER -- requirements
Module: calc1_port_requester

---
 rtl/calc1_pkg.sv | 38 +++
 rtl/calc1_req_watchdog.sv | 29 ++
 rtl/calc1_port_requester.sv | 142 ++++++++++++++
 tb/tb_calc1_port_requester.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc1_pkg.sv
// Shared definitions for the calc1 port requester: command and response
// codes, FSM state encoding and bus width constants.
package calc1_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CMD_W  = 4;
   localparam int unsigned RESP_W = 2;
   localparam int unsigned CNT_W  = 8;

   typedef enum logic [CMD_W-1:0] {
      CMD_NOP = 4'd0,
      CMD_ADD = 4'd1,
      CMD_SUB = 4'd2,
      CMD_SHL = 4'd5,
      CMD_SHR = 4'd6
   } cmd_e;

   typedef enum logic [RESP_W-1:0] {
      RESP_NONE = 2'd0,
      RESP_OK   = 2'd1,
      RESP_OVF  = 2'd2,
      RESP_INV  = 2'd3
   } resp_e;

   typedef enum logic [2:0] {
      IDLE,
      SEND1,
      SEND2,
      WAIT,
      DONE
   } state_e;

   // Any non-zero response code means the port has answered.
   function automatic logic resp_present(input logic [0:RESP_W-1] r);
      return r != RESP_NONE;
   endfunction

endpackage

// File: rtl/calc1_req_watchdog.sv
// Response-wait watchdog for the calc1 port requester. The counter is
// cleared in the cycle before WAIT is entered and counts WAIT cycles;
// expired is high during the WAIT cycle that completes TIMEOUT_CYCLES.
module calc1_req_watchdog
   import calc1_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic c_clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expired
);

   logic [CNT_W-1:0] count;

   // Count cycles spent waiting for a response.
   always_ff @(posedge c_clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (run) begin
         count <= count + 1'b1;
      end
   end

   assign expired = run && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/calc1_port_requester.sv
// Calc1 port requester: accepts one host operation at a time, drives the
// calculator port for two cycles (command+operand 1, then operand 2), waits
// for a non-zero response code and holds the result until the host takes it.
// Optional response watchdog enabled by defining CALC1_REQ_TIMEOUT_EN.
module calc1_port_requester
   import calc1_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [0:3]  op_cmd,
   input  logic [0:31] op_data1,
   input  logic [0:31] op_data2,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [0:1]  res_resp,
   output logic [0:31] res_data,
   output logic        res_timeout,
   output logic [0:3]  req_cmd_out,
   output logic [0:31] req_data_out,
   input  logic [0:1]  out_resp,
   input  logic [0:31] out_data,
   output logic        spurious_resp
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..255");
   end

   state_e      state;
   logic [0:31] data2_q;
   logic        wd_expired;

`ifdef CALC1_REQ_TIMEOUT_EN
   calc1_req_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .c_clk   (c_clk),
      .reset   (reset),
      .clear   (state == SEND2),
      .run     (state == WAIT),
      .expired (wd_expired)
   );
`else
   assign wd_expired  = 1'b0;
   assign res_timeout = 1'b0;
`endif

   // Operation sequencing FSM; all outputs registered.
   always_ff @(posedge c_clk) begin
      if (reset) begin
         state         <= IDLE;
         op_ready      <= 1'b1;
         res_valid     <= 1'b0;
         res_resp      <= '0;
         res_data      <= '0;
         req_cmd_out   <= '0;
         req_data_out  <= '0;
         spurious_resp <= 1'b0;
         data2_q       <= '0;
`ifdef CALC1_REQ_TIMEOUT_EN
         res_timeout   <= 1'b0;
`endif
      end else begin
         if (resp_present(out_resp) && state != WAIT) begin
            spurious_resp <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (op_valid) begin
                  op_ready <= 1'b0;
                  data2_q  <= op_data2;
                  if (op_cmd != CMD_NOP) begin
                     state        <= SEND1;
                     req_cmd_out  <= op_cmd;
                     req_data_out <= op_data1;
                  end else begin
                     // NOP completes locally without touching the port.
                     state     <= DONE;
                     res_valid <= 1'b1;
                     res_resp  <= '0;
                     res_data  <= '0;
`ifdef CALC1_REQ_TIMEOUT_EN
                     res_timeout <= 1'b0;
`endif
                  end
               end
            end

            SEND1: begin
               state        <= SEND2;
               req_cmd_out  <= '0;
               req_data_out <= data2_q;
            end

            SEND2: begin
               state        <= WAIT;
               req_data_out <= '0;
            end

            WAIT: begin
               // A response arriving on the expiry cycle takes priority.
               if (resp_present(out_resp)) begin
                  state     <= DONE;
                  res_valid <= 1'b1;
                  res_resp  <= out_resp;
                  res_data  <= out_data;
`ifdef CALC1_REQ_TIMEOUT_EN
                  res_timeout <= 1'b0;
`endif
               end else if (wd_expired) begin
                  state     <= DONE;
                  res_valid <= 1'b1;
                  res_resp  <= '0;
                  res_data  <= '0;
`ifdef CALC1_REQ_TIMEOUT_EN
                  res_timeout <= 1'b1;
`endif
               end
            end

            DONE: begin
               if (res_ready) begin
                  state     <= IDLE;
                  res_valid <= 1'b0;
                  op_ready  <= 1'b1;
               end
            end

            default: begin
               state    <= IDLE;
               op_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_calc1_port_requester.sv
// Self-checking bench for calc1_port_requester. The bench plays both the
// host and the calculator port; a small arithmetic calculator model supplies
// the port responses and the expected results.
module tb_calc1_port_requester;

   localparam int unsigned TO = 8;

   logic        c_clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic        op_ready;
   logic [0:3]  op_cmd;
   logic [0:31] op_data1;
   logic [0:31] op_data2;
   logic        res_valid;
   logic        res_ready;
   logic [0:1]  res_resp;
   logic [0:31] res_data;
   logic        res_timeout;
   logic [0:3]  req_cmd_out;
   logic [0:31] req_data_out;
   logic [0:1]  out_resp;
   logic [0:31] out_data;
   logic        spurious_resp;

   int checks = 0;
   int errors = 0;

   calc1_port_requester #(
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .c_clk         (c_clk),
      .reset         (reset),
      .op_valid      (op_valid),
      .op_ready      (op_ready),
      .op_cmd        (op_cmd),
      .op_data1      (op_data1),
      .op_data2      (op_data2),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_resp      (res_resp),
      .res_data      (res_data),
      .res_timeout   (res_timeout),
      .req_cmd_out   (req_cmd_out),
      .req_data_out  (req_data_out),
      .out_resp      (out_resp),
      .out_data      (out_data),
      .spurious_resp (spurious_resp)
   );

   always #5 c_clk = ~c_clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running, required completion");
      $fatal(1, "bench time limit");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge c_clk);
      #1;
   endtask

   // Calculator port behaviour: unsigned arithmetic, codes OK/OVF/INV.
   task automatic calc(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       output logic [1:0] r, output logic [31:0] d);
      logic [32:0] wide;
      case (cmd)
         4'd1: begin wide = {1'b0, a} + {1'b0, b}; d = wide[31:0]; r = wide[32] ? 2'd2 : 2'd1; end
         4'd2: begin d = a - b; r = (a < b) ? 2'd2 : 2'd1; end
         4'd5: begin d = a << b[4:0]; r = 2'd1; end
         4'd6: begin d = a >> b[4:0]; r = 2'd1; end
         default: begin d = 32'h0; r = 2'd3; end
      endcase
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_op_ready"},  32'(op_ready), 32'd1);
      check({pfx, "_res_valid"}, 32'(res_valid), 32'd0);
      check({pfx, "_res_resp"},  32'(res_resp), 32'd0);
      check({pfx, "_res_data"},  res_data, 32'd0);
      check({pfx, "_res_to"},    32'(res_timeout), 32'd0);
      check({pfx, "_req_cmd"},   32'(req_cmd_out), 32'd0);
      check({pfx, "_req_data"},  req_data_out, 32'd0);
      check({pfx, "_spurious"},  32'(spurious_resp), 32'd0);
   endtask

   // One complete operation. delay = WAIT cycles before the port answers;
   // with the watchdog enabled, delay >= TO means the port never answers.
   task automatic do_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input int delay, input int hold);
      logic [1:0]  r, exp_r;
      logic [31:0] d, exp_d;
      logic        exp_to;
      bit          no_answer;

      check("idle_ready", 32'(op_ready), 32'd1);
      op_valid = 1'b1;
      op_cmd   = cmd;
      op_data1 = a;
      op_data2 = b;
      tick();
      op_valid = 1'b0;
      op_cmd   = 4'($urandom);
      op_data1 = $urandom;
      op_data2 = $urandom;
      check("busy_ready", 32'(op_ready), 32'd0);

      exp_r  = 2'd0;
      exp_d  = 32'd0;
      exp_to = 1'b0;
      if (cmd == 4'd0) begin
         check("nop_bus_cmd",  32'(req_cmd_out), 32'd0);
         check("nop_bus_data", req_data_out, 32'd0);
      end else begin
         check("send1_cmd",  32'(req_cmd_out), 32'(cmd));
         check("send1_data", req_data_out, a);
         tick();
         check("send2_cmd",  32'(req_cmd_out), 32'd0);
         check("send2_data", req_data_out, b);
         tick();
         check("wait_cmd",  32'(req_cmd_out), 32'd0);
         check("wait_data", req_data_out, 32'd0);
         calc(cmd, a, b, r, d);
         no_answer = 1'b0;
`ifdef CALC1_REQ_TIMEOUT_EN
         no_answer = (delay >= int'(TO));
`endif
         if (no_answer) begin
            for (int i = 0; i < int'(TO); i++) begin
               check("wait_no_valid", 32'(res_valid), 32'd0);
               tick();
            end
            exp_to = 1'b1;
         end else begin
            for (int i = 0; i < delay; i++) begin
               check("wait_no_valid", 32'(res_valid), 32'd0);
               tick();
            end
            out_resp = r;
            out_data = d;
            tick();
            out_resp = 2'd0;
            out_data = $urandom;
            exp_r = r;
            exp_d = d;
         end
      end

      check("done_valid", 32'(res_valid), 32'd1);
      check("done_resp",  32'(res_resp), 32'(exp_r));
      check("done_data",  res_data, exp_d);
      check("done_to",    32'(res_timeout), 32'(exp_to));
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_valid", 32'(res_valid), 32'd1);
         check("hold_resp",  32'(res_resp), 32'(exp_r));
         check("hold_data",  res_data, exp_d);
         check("hold_ready", 32'(op_ready), 32'd0);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("after_hs_ready", 32'(op_ready), 32'd1);
      check("after_hs_valid", 32'(res_valid), 32'd0);
   endtask

   initial begin
      logic [3:0] rc;
      reset     = 1'b1;
      op_valid  = 1'b0;
      op_cmd    = '0;
      op_data1  = '0;
      op_data2  = '0;
      res_ready = 1'b0;
      out_resp  = '0;
      out_data  = '0;
      tick();
      tick();
      check_reset_outputs("rst");
      reset = 1'b0;
      tick();

      // Directed cases.
      do_op(4'd1, 32'h5, 32'h3, 2, 0);           // ADD 5,3 -> OK, 8
      do_op(4'd2, 32'h1, 32'h2, 0, 1);           // SUB underflow -> OVF
      do_op(4'd3, 32'h1234, 32'h1, 1, 0);        // unknown cmd forwarded -> INV
      do_op(4'd0, 32'hdead, 32'hbeef, 0, 2);     // NOP completes locally
      do_op(4'd1, 32'hffffffff, 32'h1, 3, 5);    // ADD overflow, long hold
      do_op(4'd5, 32'h1, 32'd31, int'(TO) - 1, 0); // response on expiry cycle
`ifdef CALC1_REQ_TIMEOUT_EN
      do_op(4'd6, 32'h80, 32'd3, int'(TO), 2);   // watchdog expiry
`else
      do_op(4'd6, 32'h80, 32'd3, 40, 0);         // long wait never times out
`endif

      // Randomized operations.
      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 6))
            0: rc = 4'd0;
            1: rc = 4'd1;
            2: rc = 4'd2;
            3: rc = 4'd5;
            4: rc = 4'd6;
            default: rc = 4'($urandom);
         endcase
         do_op(rc, $urandom, $urandom, $urandom_range(0, int'(TO) + 1), $urandom_range(0, 3));
      end
      check("no_spurious", 32'(spurious_resp), 32'd0);

      // Reset while waiting abandons the operation.
      op_valid = 1'b1;
      op_cmd   = 4'd1;
      op_data1 = 32'h11;
      op_data2 = 32'h22;
      tick();
      op_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      check_reset_outputs("rst_wait");
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst_no_result", 32'(res_valid), 32'd0);
      end

      // Response in IDLE is spurious and sticky.
      out_resp = 2'd1;
      out_data = 32'h77;
      tick();
      out_resp = 2'd0;
      check("spur_set", 32'(spurious_resp), 32'd1);
      check("spur_idle_ready", 32'(op_ready), 32'd1);
      check("spur_no_valid", 32'(res_valid), 32'd0);
      do_op(4'd1, 32'h5, 32'h3, 1, 0);
      check("spur_sticky", 32'(spurious_resp), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("spur_cleared", 32'(spurious_resp), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
